// File: rtl/adder_pkg.sv
// Shared sizing helpers for the sliced, pipelined adder.
// chunks_fit() is evaluated at elaboration by the top to reject illegal slicings.
package adder_pkg;

   localparam int DEFAULT_CHUNK = 4;

   function automatic int chunk_count(input int width, input int chunk);
      return (chunk > 0) ? (width / chunk) : 1;
   endfunction

   function automatic bit chunks_fit(input int width, input int chunk);
      return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// Combinational CHUNK-bit ripple-carry slice; no state, zero latency, no flow control.
// c_msb_in exposes the carry into the slice MSB so the top slice can derive signed overflow.
module pipe_adder_stage
   import adder_pkg::*;
#(
   parameter int CHUNK = DEFAULT_CHUNK
)(
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] sum,
   output logic             co,
   output logic             c_msb_in
);

   logic [CHUNK:0] w_c;

   assign w_c[0] = ci;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign sum[i]   = x[i] ^ y[i] ^ w_c[i];
      assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
   end

   assign co       = w_c[CHUNK];
   assign c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into CHUNK-bit slices, one register stage per slice; latency NUM_STAGES.
// Full throughput; a stalled output (out_valid & ~out_ready) freezes every stage and drops in_ready.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = DEFAULT_CHUNK
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf
);

   localparam int NUM_STAGES = chunk_count(WIDTH, CHUNK);

   if (!chunks_fit(WIDTH, CHUNK)) begin : g_bad_params
      $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
   end

   logic             w_stall;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_ld   [NUM_STAGES];
   logic             r_vld  [NUM_STAGES];
   logic             r_c    [NUM_STAGES];
   logic [CHUNK-1:0] r_sum  [NUM_STAGES];
   logic [CHUNK-1:0] w_x    [NUM_STAGES];
   logic [CHUNK-1:0] w_y    [NUM_STAGES];
   logic [CHUNK-1:0] w_sum  [NUM_STAGES];
   logic             w_ci   [NUM_STAGES];
   logic             w_co   [NUM_STAGES];
   logic             w_cmsb [NUM_STAGES];
   logic             r_ovf;

   assign out_valid = r_vld[NUM_STAGES-1];
   assign w_stall   = out_valid & ~out_ready;
   assign in_ready  = ~w_stall;
   assign w_b_eff   = b ^ {WIDTH{sub}};

   // w_ld[k]: stage k (and every skew/deskew register aligned with it) captures this edge
   always_comb begin
      for (int k = 0; k < NUM_STAGES; k++) begin
         w_ld[k] = 1'b0;
      end
      w_ld[0] = in_valid & ~w_stall;
      for (int k = 1; k < NUM_STAGES; k++) begin
         w_ld[k] = r_vld[k-1] & ~w_stall;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            r_vld[k] <= 1'b0;
         end
      end else if (!w_stall) begin
         r_vld[0] <= in_valid;
         for (int k = 1; k < NUM_STAGES; k++) begin
            r_vld[k] <= r_vld[k-1];
         end
      end
   end

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      if (k == 0) begin : g_cin
         assign w_ci[k] = c_in;
      end else begin : g_cchain
         assign w_ci[k] = r_c[k-1];
      end

      pipe_adder_stage #(.CHUNK(CHUNK)) u_stage (
         .x        (w_x[k]),
         .y        (w_y[k]),
         .ci       (w_ci[k]),
         .sum      (w_sum[k]),
         .co       (w_co[k]),
         .c_msb_in (w_cmsb[k])
      );

      always_ff @(posedge clk) begin
         if (reset) begin
            r_sum[k] <= '0;
            r_c[k]   <= 1'b0;
         end else if (w_ld[k]) begin
            r_sum[k] <= w_sum[k];
            r_c[k]   <= w_co[k];
         end
      end
   end

   for (genvar j = 0; j < NUM_STAGES; j++) begin : g_slice
      // Operand slice j rides j skew registers so it meets its carry at stage j
      if (j == 0) begin : g_direct
         assign w_x[j] = a[CHUNK-1:0];
         assign w_y[j] = w_b_eff[CHUNK-1:0];
      end else begin : g_skew
         logic [2*CHUNK-1:0] r_skw [j];

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < j; i++) begin
                  r_skw[i] <= '0;
               end
            end else begin
               if (w_ld[0]) begin
                  r_skw[0] <= {a[j*CHUNK +: CHUNK], w_b_eff[j*CHUNK +: CHUNK]};
               end
               for (int i = 1; i < j; i++) begin
                  if (w_ld[i]) begin
                     r_skw[i] <= r_skw[i-1];
                  end
               end
            end
         end

         assign {w_x[j], w_y[j]} = r_skw[j-1];
      end

      if (j == NUM_STAGES - 1) begin : g_top_slice
         assign s[j*CHUNK +: CHUNK] = r_sum[j];
      end else begin : g_deskew
         logic [CHUNK-1:0] r_dsk [NUM_STAGES-1-j];

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int m = 0; m < NUM_STAGES - 1 - j; m++) begin
                  r_dsk[m] <= '0;
               end
            end else begin
               if (w_ld[j+1]) begin
                  r_dsk[0] <= r_sum[j];
               end
               for (int m = 1; m < NUM_STAGES - 1 - j; m++) begin
                  if (w_ld[j+1+m]) begin
                     r_dsk[m] <= r_dsk[m-1];
                  end
               end
            end
         end

         assign s[j*CHUNK +: CHUNK] = r_dsk[NUM_STAGES-2-j];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (w_ld[NUM_STAGES-1]) begin
         r_ovf <= w_cmsb[NUM_STAGES-1] ^ w_co[NUM_STAGES-1];
      end
   end

   assign c_out = r_c[NUM_STAGES-1];
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder (WIDTH=16, CHUNK=4): directed spec vectors plus a random stream
// scored against an arithmetic reference model with a result queue.
module tb_pipelined_adder;

   localparam int W  = 16;
   localparam int NS = 4;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } res_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         c_out;
   logic         ovf;

   int n_chk  = 0;
   int n_fail = 0;

   pipelined_adder #(.WIDTH(W), .CHUNK(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .c_out     (c_out),
      .ovf       (ovf)
   );

   initial forever #5 clk = ~clk;

   // Reference: whole-word arithmetic; overflow from operand/result signs.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic sb);
      logic [W-1:0] yb;
      logic [W:0]   t;
      res_t         r;
      yb  = sb ? ~y : y;
      t   = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, ci};
      r.s = t[W-1:0];
      r.c = t[W];
      r.o = (x[W-1] == yb[W-1]) && (r.s[W-1] != x[W-1]);
      return r;
   endfunction

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      n_chk++; if (s !== '0) begin n_fail++; $display("FAIL reset_s: got %h exp 0000", s); end
      n_chk++; if (c_out !== 1'b0) begin n_fail++; $display("FAIL reset_c_out: got %b exp 0", c_out); end
      n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b exp 0", ovf); end
      reset = 1'b0;
      @(negedge clk);
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
   endtask

   task automatic test_basic_latency();
      in_valid = 1'b1; a = 16'h1234; b = 16'h0001; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i <= NS; i++) begin
         #1;
         n_chk++;
         if (out_valid !== (i == NS - 1)) begin
            n_fail++; $display("FAIL basic_valid_edge%0d: got %b exp %b", i, out_valid, (i == NS - 1));
         end
         if (i == NS - 1) begin
            n_chk++;
            if ({s, c_out, ovf} !== {16'h1235, 1'b0, 1'b0}) begin
               n_fail++; $display("FAIL basic_result: got s=%h c=%b o=%b exp s=1235 c=0 o=0", s, c_out, ovf);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_arith_vectors();
      logic [W-1:0] ta [4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
      logic [W-1:0] tb [4] = '{16'h0000, 16'h0001, 16'h0007, 16'h0001};
      logic         tc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic         tu [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      res_t         te [4] = '{{16'h0000, 1'b1, 1'b0}, {16'h8000, 1'b0, 1'b1},
                               {16'hFFFE, 1'b0, 1'b0}, {16'h7FFF, 1'b1, 1'b1}};
      for (int v = 0; v < 4; v++) begin
         in_valid = 1'b1; a = ta[v]; b = tb[v]; c_in = tc[v]; sub = tu[v];
         @(negedge clk);
         in_valid = 1'b0;
         repeat (NS - 1) @(negedge clk);
         #1;
         n_chk++;
         if (out_valid !== 1'b1 || {s, c_out, ovf} !== te[v]) begin
            n_fail++;
            $display("FAIL arith_vec%0d: got v=%b s=%h c=%b o=%b exp v=1 s=%h c=%b o=%b",
                     v, out_valid, s, c_out, ovf, te[v].s, te[v].c, te[v].o);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1; c_in = 1'b0; sub = 1'b0;
      for (int cyc = 0; cyc < NS + 10; cyc++) begin
         in_valid = (cyc < 8);
         a = 16'(cyc);
         b = 16'(cyc * 16'h0100);
         #1;
         n_chk++;
         if (out_valid !== (cyc >= NS && cyc < NS + 8)) begin
            n_fail++; $display("FAIL b2b_valid_cyc%0d: got %b exp %b", cyc, out_valid, (cyc >= NS && cyc < NS + 8));
         end
         if (cyc >= NS && cyc < NS + 8) begin
            n_chk++;
            if (s !== 16'((cyc - NS) * 16'h0101)) begin
               n_fail++; $display("FAIL b2b_s_op%0d: got %h exp %h", cyc - NS, s, 16'((cyc - NS) * 16'h0101));
            end
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      res_t q [$];
      res_t e;
      res_t hold;
      int   idx = 0;
      int   del = 0;
      hold = '0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         in_valid  = (idx < 10);
         a         = 16'(idx * 16'h1111 + 16'h0007);
         b         = 16'(idx * 16'h0F03);
         c_in      = idx[0];
         sub       = idx[1];
         out_ready = !(cyc >= 6 && cyc < 9);
         #1;
         if (!out_ready) begin
            n_chk++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
               n_fail++; $display("FAIL bp_stall_cyc%0d: got in_ready=%b out_valid=%b exp 0/1", cyc, in_ready, out_valid);
            end
            if (cyc == 6) hold = {s, c_out, ovf};
            else begin
               n_chk++;
               if ({s, c_out, ovf} !== hold) begin
                  n_fail++; $display("FAIL bp_frozen_cyc%0d: got %h exp %h", cyc, {s, c_out, ovf}, hold);
               end
            end
         end
         if (out_valid && out_ready) begin
            n_chk++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL bp_extra: got s=%h exp no result", s);
            end else begin
               e = q.pop_front();
               del++;
               if ({s, c_out, ovf} !== e) begin
                  n_fail++; $display("FAIL bp_result%0d: got %h exp %h", del - 1, {s, c_out, ovf}, e);
               end
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, c_in, sub));
            idx++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_chk++;
      if (del != 10 || q.size() != 0) begin
         n_fail++; $display("FAIL bp_count: got delivered=%0d pending=%0d exp 10/0", del, q.size());
      end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b1; c_in = 1'b0; sub = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = 16'(16'hA000 + i); b = 16'(i);
         @(negedge clk);
      end
      in_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         n_chk++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_ghost_cyc%0d: got out_valid=%b s=%h exp 0", i, out_valid, s);
         end
         @(negedge clk);
      end
      in_valid = 1'b1; a = 16'h00F0; b = 16'h0F0F;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < NS; i++) begin
         #1;
         n_chk++;
         if (out_valid !== (i == NS - 1)) begin
            n_fail++; $display("FAIL midreset_latency_edge%0d: got %b exp %b", i, out_valid, (i == NS - 1));
         end
         if (i == NS - 1) begin
            n_chk++;
            if ({s, c_out, ovf} !== {16'h0FFF, 1'b0, 1'b0}) begin
               n_fail++; $display("FAIL midreset_result: got s=%h c=%b o=%b exp s=0fff c=0 o=0", s, c_out, ovf);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random_stream();
      res_t q [$];
      res_t e;
      res_t hold;
      logic stall_prev = 1'b0;
      int   acc = 0;
      int   del = 0;
      hold = '0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (cyc < 260) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = 16'($urandom);
            b         = 16'($urandom);
            c_in      = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         #1;
         if (stall_prev) begin
            n_chk++;
            if (out_valid !== 1'b1 || {s, c_out, ovf} !== hold) begin
               n_fail++; $display("FAIL rnd_hold_cyc%0d: got v=%b %h exp v=1 %h", cyc, out_valid, {s, c_out, ovf}, hold);
            end
         end
         n_chk++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            n_fail++; $display("FAIL rnd_in_ready_cyc%0d: got %b exp %b", cyc, in_ready, !(out_valid && !out_ready));
         end
         if (out_valid && out_ready) begin
            n_chk++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL rnd_extra_cyc%0d: got s=%h exp no result", cyc, s);
            end else begin
               e = q.pop_front();
               del++;
               if ({s, c_out, ovf} !== e) begin
                  n_fail++; $display("FAIL rnd_result%0d: got %h exp %h", del - 1, {s, c_out, ovf}, e);
               end
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, c_in, sub));
            acc++;
         end
         stall_prev = out_valid && !out_ready;
         hold       = {s, c_out, ovf};
         @(negedge clk);
      end
      n_chk++;
      if (del != acc || q.size() != 0) begin
         n_fail++; $display("FAIL rnd_count: got delivered=%0d accepted=%0d pending=%0d", del, acc, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic_latency();
      test_arith_vectors();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      test_random_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
